z80_io_write_capture: RTL and testbench

//   Bus responder that captures Z8S180 I/O write cycles (OUT instructions) addressed to a

---
 rtl/z80_io_write_capture_pkg.sv | 34 +++
 rtl/z80_io_write_capture_if.sv | 34 +++
 rtl/z80_io_write_capture_fifo.sv | 64 ++++++
 rtl/z80_io_write_capture.sv | 167 ++++++++++++++++
 tb/tb_z80_io_write_capture.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/z80_io_write_capture_pkg.sv
// Shared types for the Z80 I/O write capture block: FSM states, queued entry.
// ST_STALL only exists when WAIT_ON_FULL_EN is defined.
package z80_bus_pkg;

   localparam int ENTRY_W     = 16;
   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      ST_ARM,
      ST_IDLE,
      ST_SAMPLE,
      ST_PUSH,
`ifdef WAIT_ON_FULL_EN
      ST_DONE,
      ST_STALL
`else
      ST_DONE
`endif
   } state_t;

   typedef struct packed {
      logic [7:0] port;
      logic [7:0] data;
   } entry_t;

   function automatic logic port_hit(
      input logic [7:0] a,
      input logic [7:0] base,
      input logic [7:0] mask
   );
      return (a & mask) == (base & mask);
   endfunction

endpackage

// File: rtl/z80_io_write_capture_if.sv
// CPU bus pins plus consumer-side FIFO read port of the I/O write capture block.
interface z80_io_write_capture_if #(
   parameter int DEPTH = 8
);

   logic [7:0]             a_lo;
   logic [7:0]             d_in;
   logic                   iorq_n;
   logic                   wr_n;
   logic                   m1_n;
   logic                   wait_n;
   logic                   rd_valid;
   logic [7:0]             rd_port;
   logic [7:0]             rd_data;
   logic                   rd_ready;
   logic [$clog2(DEPTH):0] count;
   logic                   ovf;
   logic                   ovf_clr;

   modport slave (
      input  a_lo, d_in, iorq_n, wr_n, m1_n,
      input  rd_ready, ovf_clr,
      output wait_n, rd_valid, rd_port, rd_data,
      output count, ovf
   );

   modport master (
      output a_lo, d_in, iorq_n, wr_n, m1_n,
      output rd_ready, ovf_clr,
      input  wait_n, rd_valid, rd_port, rd_data,
      input  count, ovf
   );

endinterface

// File: rtl/z80_io_write_capture_fifo.sv
// Show-ahead FIFO of captured {port, data} entries; push+pop when full is legal.
module z80_cap_fifo
   import z80_bus_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  entry_t                 din_i,
   input  logic                   pop_i,
   output entry_t                 dout_o,
   output logic                   valid_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;
   logic               do_push;
   logic               do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign valid_o = ~empty_o;
   assign count_o = count_q;

endmodule

// File: rtl/z80_io_write_capture.sv
// Captures Z8S180 OUT cycles hitting a port window into a FIFO.
// WAIT_ON_FULL_EN: stall the CPU via wait_n instead of dropping on full.
module z80_io_write_capture
   import z80_bus_pkg::*;
#(
   parameter int         DEPTH     = 8,
   parameter logic [7:0] PORT_BASE = 8'h00,
   parameter logic [7:0] PORT_MASK = 8'hF0
) (
   input logic                  hwclk,
   input logic                  reset_n,
   z80_io_write_capture_if.slave bus
);

   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] iorq_q;
   logic [SYNC_STAGES-1:0] wr_q;
   logic [SYNC_STAGES-1:0] m1_q;
   logic [PRIME_W-1:0]     prime_q;
   logic                   iorq_s;
   logic                   wr_s;
   logic                   m1_s;
   logic                   primed;
   logic                   wr_cyc;
   logic                   hit;

   state_t     state_q;
   state_t     state_d;
   entry_t     ent_q;
   entry_t     ent_d;
   entry_t     head;
   logic       push;
   logic       pop;
   logic       full;
   logic       empty;
   logic       valid;
   logic       set_ovf;
   logic       ovf_q;
   logic       ovf_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge hwclk or negedge reset_n) begin
      if (!reset_n) begin
         iorq_q  <= '1;
         wr_q    <= '1;
         m1_q    <= '1;
         prime_q <= '0;
      end else begin
         iorq_q <= {iorq_q[SYNC_STAGES-2:0], bus.iorq_n};
         wr_q   <= {wr_q[SYNC_STAGES-2:0], bus.wr_n};
         m1_q   <= {m1_q[SYNC_STAGES-2:0], bus.m1_n};
         if (!primed) prime_q <= prime_q + 1'b1;
      end
   end

   // Reset values in the synchronizers are not real pin samples; ARM waits them out.
   assign primed = (prime_q == PRIME_W'(SYNC_STAGES));
   assign iorq_s = iorq_q[SYNC_STAGES-1];
   assign wr_s   = wr_q[SYNC_STAGES-1];
   assign m1_s   = m1_q[SYNC_STAGES-1];
   assign wr_cyc = ~iorq_s & ~wr_s & m1_s;
   assign hit    = port_hit(bus.a_lo, PORT_BASE, PORT_MASK);
   assign pop    = bus.rd_ready & ~empty;

`ifdef WAIT_ON_FULL_EN
   logic wait_q;
   logic wait_d;
`endif

   always_comb begin
      state_d = state_q;
      ent_d   = ent_q;
      push    = 1'b0;
      set_ovf = 1'b0;
`ifdef WAIT_ON_FULL_EN
      wait_d  = 1'b1;
`endif
      unique case (state_q)
         ST_ARM: begin
            if (primed & iorq_s & wr_s) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (wr_cyc) state_d = hit ? ST_SAMPLE : ST_DONE;
         end
         ST_SAMPLE: begin
            ent_d   = '{port: bus.a_lo, data: bus.d_in};
            state_d = ST_PUSH;
         end
         ST_PUSH: begin
            if (~full | pop) begin
               push    = 1'b1;
               state_d = ST_DONE;
            end else begin
`ifdef WAIT_ON_FULL_EN
               wait_d  = 1'b0;
               state_d = ST_STALL;
`else
               set_ovf = 1'b1;
               state_d = ST_DONE;
`endif
            end
         end
`ifdef WAIT_ON_FULL_EN
         ST_STALL: begin
            wait_d = 1'b0;
            if (~full | pop) begin
               push    = 1'b1;
               wait_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            if (iorq_s | wr_s) state_d = ST_IDLE;
         end
         default: state_d = ST_ARM;
      endcase
   end

   assign ovf_d = set_ovf | (ovf_q & ~bus.ovf_clr);

   always_ff @(posedge hwclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_ARM;
         ent_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ent_q   <= ent_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef WAIT_ON_FULL_EN
   always_ff @(posedge hwclk or negedge reset_n) begin
      if (!reset_n) wait_q <= 1'b1;
      else          wait_q <= wait_d;
   end
   assign bus.wait_n = wait_q;
`else
   assign bus.wait_n = 1'b1;
`endif

   z80_cap_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (hwclk),
      .rst_n   (reset_n),
      .push_i  (push),
      .din_i   (ent_q),
      .pop_i   (bus.rd_ready),
      .dout_o  (head),
      .valid_o (valid),
      .full_o  (full),
      .empty_o (empty),
      .count_o (cnt)
   );

   assign bus.rd_valid = valid;
   assign bus.rd_port  = head.port;
   assign bus.rd_data  = head.data;
   assign bus.count    = cnt;
   assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_z80_io_write_capture.sv
// Randomized bus-cycle bench for z80_io_write_capture with a queue reference model.
module tb_z80_io_write_capture;
   import z80_bus_pkg::*;

   localparam int         DEPTH = 8;
   localparam logic [7:0] BASE  = 8'h00;
   localparam logic [7:0] MASK  = 8'hF0;

   logic hwclk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   entry_t exp_q[$];
   bit   exp_ovf = 1'b0;

   z80_io_write_capture_if #(.DEPTH(DEPTH)) bus ();

   z80_io_write_capture #(
      .DEPTH     (DEPTH),
      .PORT_BASE (BASE),
      .PORT_MASK (MASK)
   ) dut (
      .hwclk   (hwclk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #20 hwclk = ~hwclk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference: an OUT to a window port queues an entry unless the FIFO is full.
   task automatic model_out(input logic [7:0] port, input logic [7:0] data,
                            input bit is_wr, input bit coinc_pop);
      entry_t e;
      if (!is_wr) return;
      if ((port & MASK) != (BASE & MASK)) return;
      e.port = port;
      e.data = data;
`ifdef WAIT_ON_FULL_EN
      exp_q.push_back(e);
`else
      if (exp_q.size() < DEPTH || coinc_pop) exp_q.push_back(e);
      else exp_ovf = 1'b1;
`endif
   endtask

   always @(negedge hwclk) begin
      if (reset_n && bus.rd_valid && bus.rd_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected", {bus.rd_port, bus.rd_data}, 0);
         end else begin
            entry_t e;
            e = exp_q.pop_front();
            chk("sb_head", {bus.rd_port, bus.rd_data}, {e.port, e.data});
         end
      end
   end

   task automatic cpu_cycle(input logic [7:0] port, input logic [7:0] data,
                            input bit ack, input int hold,
                            input bit chk_lat, input int pop_at);
      model_out(port, data, !ack, pop_at == 4);
      @(posedge hwclk); #2;
      bus.a_lo   = port;
      bus.d_in   = data;
      bus.iorq_n = 1'b0;
      if (ack) bus.m1_n = 1'b0;
      else     bus.wr_n = 1'b0;
      for (int c = 1; c <= hold; c++) begin
         @(posedge hwclk); #1;
         if (chk_lat && c == 4) chk("lat_early", bus.rd_valid, 0);
         if (chk_lat && c == 5) chk("lat_valid", bus.rd_valid, 1);
         #1;
         if (c == pop_at) bus.rd_ready = 1'b1;
         else if (pop_at > 0 && c == pop_at + 1) bus.rd_ready = 1'b0;
      end
`ifdef WAIT_ON_FULL_EN
      begin
         int g = 0;
         while (bus.wait_n == 1'b0 && g < 200) begin
            @(posedge hwclk); #2;
            g++;
         end
         chk("wait_bound", int'(g < 200), 1);
      end
`endif
      bus.iorq_n = 1'b1;
      bus.wr_n   = 1'b1;
      bus.m1_n   = 1'b1;
      repeat (5) @(posedge hwclk);
      #2;
   endtask

   task automatic drain();
      int g = 0;
      bus.rd_ready = 1'b1;
      while (bus.count != 0 && g < 100) begin
         @(posedge hwclk); #2;
         g++;
      end
      chk("drain_bound", int'(g < 100), 1);
      chk("sb_empty", exp_q.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.a_lo     = 8'h00;
      bus.d_in     = 8'h00;
      bus.iorq_n   = 1'b1;
      bus.wr_n     = 1'b1;
      bus.m1_n     = 1'b1;
      bus.rd_ready = 1'b0;
      bus.ovf_clr  = 1'b0;
      repeat (3) @(posedge hwclk);
      #2 reset_n = 1'b1;
      @(posedge hwclk); #1;
      chk("rst_valid", bus.rd_valid, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_wait", bus.wait_n, 1);
      chk("rst_port", bus.rd_port, 0);
      chk("rst_data", bus.rd_data, 0);
      repeat (4) @(posedge hwclk);
      #2;

      cpu_cycle(8'h05, 8'hA5, 1'b0, 7, 1'b1, -1);
      chk("one_count", bus.count, 1);
      chk("one_head", {bus.rd_port, bus.rd_data}, 16'h05A5);
      drain();

      cpu_cycle(8'h25, 8'h11, 1'b0, 7, 1'b0, -1);
      cpu_cycle(8'h03, 8'hFF, 1'b1, 7, 1'b0, -1);
      chk("nomatch_count", bus.count, 0);

      for (int i = 0; i < 30; i++) begin
         logic [7:0] p;
         p = 8'($urandom);
         if ($urandom_range(0, 1) == 1) p[7:4] = 4'h0;
         cpu_cycle(p, 8'($urandom), $urandom_range(0, 9) == 0,
                   int'($urandom_range(6, 9)), 1'b0, -1);
      end
      drain();

      bus.rd_ready = 1'b0;
      @(posedge hwclk); #2;
      for (int i = 0; i < DEPTH; i++)
         cpu_cycle(8'h00 + 8'(i), 8'h30 + 8'(i), 1'b0, 6, 1'b0, -1);
      chk("fill_count", bus.count, DEPTH);
`ifdef WAIT_ON_FULL_EN
      fork
         cpu_cycle(8'h0F, 8'hEE, 1'b0, 7, 1'b0, -1);
         begin
            int g = 0;
            while (bus.wait_n == 1'b1 && g < 20) begin
               @(posedge hwclk); #1;
               g++;
            end
            chk("stall_wait_low", bus.wait_n, 0);
            #1 bus.rd_ready = 1'b1;
            @(posedge hwclk); #2 bus.rd_ready = 1'b0;
         end
      join
      chk("stall_wait_high", bus.wait_n, 1);
      chk("stall_ovf", bus.ovf, 0);
`else
      cpu_cycle(8'h0F, 8'hEE, 1'b0, 7, 1'b0, -1);
      chk("drop_ovf", bus.ovf, int'(exp_ovf));
      chk("drop_wait", bus.wait_n, 1);
`endif
      chk("full_count", bus.count, DEPTH);
      chk("full_head", {bus.rd_port, bus.rd_data},
          {exp_q[0].port, exp_q[0].data});
      @(posedge hwclk); #2 bus.ovf_clr = 1'b1;
      @(posedge hwclk); #1;
      chk("ovf_clr", bus.ovf, 0);
      #1 bus.ovf_clr = 1'b0;

      cpu_cycle(8'h0A, 8'h5C, 1'b0, 7, 1'b0, 4);
      chk("pp_count", bus.count, DEPTH);
      chk("pp_ovf", bus.ovf, 0);
      drain();

      bus.rd_ready = 1'b1;
      @(posedge hwclk); #2;
      bus.a_lo   = 8'h05;
      bus.d_in   = 8'h77;
      bus.iorq_n = 1'b0;
      bus.wr_n   = 1'b0;
      repeat (3) @(posedge hwclk);
      #2 reset_n = 1'b0;
      repeat (2) @(posedge hwclk);
      #2 reset_n = 1'b1;
      repeat (7) @(posedge hwclk);
      #2;
      bus.iorq_n = 1'b1;
      bus.wr_n   = 1'b1;
      repeat (6) @(posedge hwclk);
      #1;
      chk("rstmid_count", bus.count, 0);
      chk("rstmid_valid", bus.rd_valid, 0);
      #1;
      cpu_cycle(8'h07, 8'h42, 1'b0, 7, 1'b0, -1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
